// File: rtl/div_unit_pkg.sv
// Shared widths, state codes and handshake levels for the multi-cycle divider.
// The helper returns the magnitude of an operand when signed division is requested.
package div_unit_pkg;

    localparam int DataWidth       = 32;
    localparam int DoubleDataWidth = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    function automatic logic [DataWidth-1:0] abs_if_signed(
        input logic [DataWidth-1:0] value,
        input logic                 is_signed
    );
        return (is_signed && value[DataWidth-1]) ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring step: trial-subtract the divisor from the partial remainder
// and either shift (borrow) or keep the difference and shift in a quotient 1.
module div_step
    import div_unit_pkg::*;
(
    input  logic [DoubleDataWidth-1:0] work,
    input  logic [DataWidth-1:0]       divisor,
    output logic [DoubleDataWidth:0]   work_next
);

    logic [DataWidth:0] diff;

    assign diff = {1'b0, work[DoubleDataWidth-1:DataWidth]} - {1'b0, divisor};

    // diff[32] set means the subtraction borrowed, so this quotient bit is 0.
    assign work_next = diff[DataWidth] ? {work, 1'b0}
                                       : {diff[DataWidth-1:0], work[DataWidth-1:0], 1'b1};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit: 32 restoring iterations, sign correction,
// and a ready handshake that the execute stage holds its stall request against.
//
// state     | meaning
// DivFree   | idle, waiting for an accepted start
// DivByZero | divisor was zero, load a zero result
// DivOn     | iterating, one quotient bit per cycle
// DivEnd    | result valid, held until start_i drops
module div_unit
    import div_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       signed_div_i,
    input  logic [DataWidth-1:0]       opdata1_i,
    input  logic [DataWidth-1:0]       opdata2_i,
    input  logic                       start_i,
    input  logic                       annul_i,
    output logic [DoubleDataWidth-1:0] result_o,
    output logic                       ready_o
);

    div_state_e                  state, state_nx;
    logic [5:0]                  cnt, cnt_nx;
    logic [DoubleDataWidth:0]    work, work_nx, work_step;
    logic [DataWidth-1:0]        divisor, divisor_nx;
    logic                        sign1, sign1_nx, sign2, sign2_nx;
    logic                        is_signed, is_signed_nx;
    logic [DoubleDataWidth-1:0]  result_nx;
    logic                        ready_nx;
    logic [DataWidth-1:0]        quot_fix, rem_fix;

    div_step u_step (
        .work      (work[DoubleDataWidth-1:0]),
        .divisor   (divisor),
        .work_next (work_step)
    );

    // Results truncate toward zero: quotient sign from both operands, remainder follows the dividend.
    assign quot_fix = (is_signed && (sign1 ^ sign2)) ? (~work_step[DataWidth-1:0] + 32'd1)
                                                     : work_step[DataWidth-1:0];
    assign rem_fix  = (is_signed && sign1) ? (~work_step[DoubleDataWidth:DataWidth+1] + 32'd1)
                                           : work_step[DoubleDataWidth:DataWidth+1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= DivFree;
            cnt       <= '0;
            work      <= '0;
            divisor   <= '0;
            sign1     <= 1'b0;
            sign2     <= 1'b0;
            is_signed <= 1'b0;
            result_o  <= '0;
            ready_o   <= DivResultNotReady;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            work      <= work_nx;
            divisor   <= divisor_nx;
            sign1     <= sign1_nx;
            sign2     <= sign2_nx;
            is_signed <= is_signed_nx;
            result_o  <= result_nx;
            ready_o   <= ready_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        work_nx      = work;
        divisor_nx   = divisor;
        sign1_nx     = sign1;
        sign2_nx     = sign2;
        is_signed_nx = is_signed;
        result_nx    = result_o;
        ready_nx     = ready_o;
        case (state)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    sign1_nx     = opdata1_i[DataWidth-1];
                    sign2_nx     = opdata2_i[DataWidth-1];
                    is_signed_nx = signed_div_i;
                    if (opdata2_i == '0) begin
                        state_nx = DivByZero;
                    end else begin
                        work_nx    = {32'b0, abs_if_signed(opdata1_i, signed_div_i), 1'b0};
                        divisor_nx = abs_if_signed(opdata2_i, signed_div_i);
                        cnt_nx     = '0;
                        state_nx   = DivOn;
                    end
                end
            end
            DivByZero: begin
                result_nx = '0;
                ready_nx  = DivResultReady;
                state_nx  = DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    state_nx = DivFree;
                end else begin
                    work_nx = work_step;
                    cnt_nx  = cnt + 6'd1;
                    // The 32nd step completes the quotient, so register the result on that same edge.
                    if (cnt == 6'd31) begin
                        result_nx = {rem_fix, quot_fix};
                        ready_nx  = DivResultReady;
                        state_nx  = DivEnd;
                    end
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    result_nx = '0;
                    ready_nx  = DivResultNotReady;
                    state_nx  = DivFree;
                end
            end
            default: state_nx = DivFree;
        endcase
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed bench for div_unit against a cycle-level behavioural model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        signed_div;
    logic [31:0] opdata1, opdata2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    div_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference quotient/remainder straight from the arithmetic rules.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end
        return {r, q};
    endfunction

    // Behavioural model: idle / busy-countdown / done.
    int          m_phase = 0;
    int          m_left  = 0;
    logic        m_bz    = 1'b0;
    logic [63:0] m_pend  = '0;
    logic [63:0] m_result = '0;
    logic        m_ready  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase  = 0;
            m_left   = 0;
            m_ready  = 1'b0;
            m_result = '0;
        end else begin
            case (m_phase)
                0: if (start && !annul) begin
                    m_pend  = ref_div(opdata1, opdata2, signed_div);
                    m_bz    = (opdata2 == 32'd0);
                    m_left  = m_bz ? 1 : 32;
                    m_phase = 1;
                end
                1: if (!m_bz && annul) begin
                    m_phase = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_ready  = 1'b1;
                        m_result = m_pend;
                        m_phase  = 2;
                    end
                end
                default: if (!start) begin
                    m_phase  = 0;
                    m_ready  = 1'b0;
                    m_result = '0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ready", 64'(ready), 64'(m_ready));
            check("model_result", result, m_result);
        end
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold,
                           output logic [63:0] res, output int lat);
        @(negedge clk);
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        start      = 1'b1;
        lat        = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            lat = k;
            if (k == 1) begin
                opdata1    = $urandom;
                opdata2    = $urandom;
                signed_div = 1'($urandom);
            end
            if (ready) break;
        end
        if (!ready) check("ready_timeout", 64'(ready), 64'd1);
        res = result;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("end_hold_result", result, res);
            check("end_hold_ready", 64'(ready), 64'd1);
        end
        start = 1'b0;
        @(negedge clk);
        check("exit_ready", 64'(ready), 64'd0);
        check("exit_result", result, 64'd0);
    endtask

    logic [63:0] res;
    int          lat;
    logic [31:0] ra, rb;
    logic        rs;

    initial begin
        rst_n = 1'b0; start = 1'b0; annul = 1'b0;
        signed_div = 1'b0; opdata1 = '0; opdata2 = '0;

        check("ref_100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h0000_0002_0000_000E);
        check("ref_m7_2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), 64'hFFFF_FFFF_FFFF_FFFD);
        check("ref_7_m2", ref_div(32'd7, 32'hFFFF_FFFE, 1'b1), 64'h0000_0001_FFFF_FFFD);
        check("ref_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), 64'h0000_0000_8000_0000);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);

        run_div(32'd100, 32'd7, 1'b0, 0, res, lat);
        check("udiv_100_7", res, 64'h0000_0002_0000_000E);
        check("udiv_latency", 64'(lat), 64'd33);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, res, lat);
        check("sdiv_m7_2", res, 64'hFFFF_FFFF_FFFF_FFFD);
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, res, lat);
        check("sdiv_7_m2", res, 64'h0000_0001_FFFF_FFFD);
        run_div(32'd5, 32'd0, 1'b0, 3, res, lat);
        check("div_zero", res, 64'd0);
        check("div_zero_latency", 64'(lat), 64'd2);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, res, lat);
        check("sdiv_ovf", res, 64'h0000_0000_8000_0000);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, res, lat);
        check("udiv_max_1", res, 64'h0000_0000_FFFF_FFFF);

        // Annul in the 10th iteration cycle.
        @(negedge clk);
        opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        check("annul_ready", 64'(ready), 64'd0);
        run_div(32'd9, 32'd3, 1'b0, 0, res, lat);
        check("after_annul_9_3", res, 64'h0000_0000_0000_0003);
        check("after_annul_latency", 64'(lat), 64'd33);

        // Reset in the middle of an iteration (cnt = 20).
        @(negedge clk);
        opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (21) @(negedge clk);
        rst_n = 1'b0; start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrun_reset_ready", 64'(ready), 64'd0);
        check("midrun_reset_result", result, 64'd0);

        // start together with annul in idle must not be accepted.
        @(negedge clk);
        opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1; annul = 1'b1;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        repeat (40) @(negedge clk);
        check("start_annul_ready", 64'(ready), 64'd0);

        run_div(32'd1000, 32'd3, 1'b0, 0, res, lat);
        check("after_reset_div", res, 64'h0000_0001_0000_014D);

        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'd1;
                2: rb = 32'hFFFF_FFFF;
                3: rb = $urandom_range(1, 15);
                4: ra = 32'h8000_0000;
                5: ra = $urandom_range(0, 20);
                default: ;
            endcase
            run_div(ra, rb, rs, $urandom_range(0, 2), res, lat);
            check("rand_result", res, ref_div(ra, rb, rs));
            check("rand_latency", 64'(lat), (rb == 32'd0) ? 64'd2 : 64'd33);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider that the execute stage hands DIV/DIVU to, mirroring how MADD/MSUB span cycles. It owns a radix-2 restoring iteration loop and a four-state controller. It returns {remainder, quotient} for the HI/LO write and gives the execute stage a ready handshake, which the stage uses to hold its stall request. The block sits beside the execute stage, clocked with the pipeline, and drives no pipeline registers directly.

## Interface
- No parameters; widths come from `DataWidth` (32) and `DoubleDataWidth` (64).
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset rst_n, synchronous, active-low.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  in  32  dividend; sampled on accept.
- opdata2_i  in  32  divisor; sampled on accept.
- start_i  in  1  request; held high by execute stage until it sees ready_o.
- annul_i  in  1  cancel in-flight division (flush or exception).
- result_o  out  64  {remainder[63:32] → HI, quotient[31:0] → LO}; registered.
- ready_o  out  1  result_o valid; registered.

## Operation
- States: IDLE, BY_ZERO, ON, END.
- **IDLE**, on start_i=1 and annul_i=0 (accept):
  - If opdata2_i==0, go to BY_ZERO.
  - Otherwise latch |opdata1_i| and |opdata2_i| (absolute value only when signed_div_i=1).
  - Latch both sign bits and signed_div_i.
  - Clear the iteration counter cnt (6 bits) and go to ON.
- **BY_ZERO**: load a zero result and go to END next cycle.
- **ON**, one quotient bit per cycle:
  - Working register is 65 bits, initialised to {32'b0, |dividend|, 1'b0}.
  - diff = work[63:32] − {1'b0, divisor} (33 bits).
  - On borrow: work <<= 1.
  - Otherwise: work = {diff[31:0], work[31:0], 1'b1}.
  - cnt increments each cycle. After cnt reaches 32:
    - quotient = work[31:0] and remainder = work[64:33].
    - Signed correction: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
    - Register result_o and go to END.
- **ON** with annul_i=1: go to IDLE immediately, with no result and ready_o never asserted.
- **END**:
  - ready_o=1 and result_o is held stable.
  - Stay in END while start_i=1.
  - When start_i=0, go to IDLE; result_o and ready_o clear to 0 on that transition.
- Arithmetic rules:
  - Truncation toward zero; MIPS semantics.
  - 0x80000000 / −1 (signed) gives quotient 0x80000000 and remainder 0, with no trap.
- annul_i in IDLE or END blocks acceptance; END still exits on start_i=0.
- Simultaneous start_i and annul_i in IDLE: annul wins, nothing is accepted.

## Timing
- Reset: state=IDLE, result_o=0, ready_o=0, cnt=0, work=0.
  - Reset applies on any clock edge with rst_n=0, including mid-ON; the in-flight operation is dropped.
- Accept at edge T. State is ON during T+1..T+32; END at T+33 with ready_o=1.
  - Total latency: 33 cycles.
- Divide by zero: BY_ZERO at T+1, END at T+2 with ready_o=1 and result_o=0.
- The execute stage stalls the pipeline while start_i=1 and ready_o=0. It captures result_o in the cycle ready_o=1 and drops start_i the next cycle.
- A back-to-back division needs one IDLE cycle between END and the next accept.
- Operand inputs are ignored outside the accept cycle.

## Structure
- Shared define file (alongside existing opcode/width macros) holds:
  - `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2-bit state codes).
  - `DivResultReady` / `DivResultNotReady`.
  - `DivStart` / `DivStop`.
- Natural sub-module: `div_step`, a combinational 33-bit subtract-and-select producing the next work value.
- Controller FSM, counter and sign correction stay in div_unit.

## Test plan
- Unsigned 100 / 7: accept at T → ready_o=1 at T+33, result_o=0x00000002_0000000E; busy for exactly 32 cycles.
- Signed −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero (5 / 0): ready_o=1 at T+2, result_o=0. Hold start_i 3 extra cycles → result and ready_o stay stable; drop start_i → IDLE and outputs 0 next cycle.
- Signed 0x80000000 / 0xFFFFFFFF → result_o=0x00000000_80000000. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- annul_i pulsed in the 10th ON cycle → IDLE next cycle, ready_o stays 0. A new 9/3 accepted one cycle later → quotient 3, remainder 0 after 33 cycles.
- rst_n low for one cycle mid-ON (cnt=20) → all outputs 0, state IDLE next cycle. start_i+annul_i together in IDLE → no accept.
